// File: rtl/demux_12_if.sv
// Handshake bundle for demux_12: one upstream valid/ready link with a channel
// selector, and two downstream valid/ready channels.
interface demux_12_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  selector;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic                  valid_out_0;
  logic                  ready_in_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic                  valid_out_1;
  logic                  ready_in_1;

  modport master (
    output data_in, valid_in, selector, ready_in_0, ready_in_1,
    input  ready_out, data_out_0, valid_out_0, data_out_1, valid_out_1
  );

  modport slave (
    input  data_in, valid_in, selector, ready_in_0, ready_in_1,
    output ready_out, data_out_0, valid_out_0, data_out_1, valid_out_1
  );
endinterface

// File: rtl/demux_12.sv
// Buffered 1:2 demultiplexer with one FIFO per output channel.
// Optional saturating per-channel push counters when DEMUX_STATS_EN is defined.
module demux_12 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  demux_12_if.slave       link
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]      count_0,
  output logic [7:0]      count_1
`endif
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem    [2][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [2];
  logic [PTR_W-1:0]      rd_ptr [2];
  logic [OCC_W-1:0]      occ    [2];
  logic [DATA_WIDTH-1:0] head   [2];
  logic [1:0]            full;
  logic [1:0]            empty;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            ready_cons;
  logic                  accept;

  // Upstream ready looks only at the selected channel's registered occupancy.
  always_comb begin
    ready_cons = {link.ready_in_1, link.ready_in_0};
    for (int unsigned k = 0; k < 2; k++) begin
      full[k]  = (occ[k] == OCC_W'(FIFO_DEPTH));
      empty[k] = (occ[k] == '0);
      head[k]  = empty[k] ? '0 : mem[k][rd_ptr[k]];
    end
    accept = link.valid_in & ~full[link.selector];
    for (int unsigned k = 0; k < 2; k++) begin
      push[k] = accept & (link.selector == 1'(k));
      pop[k]  = ~empty[k] & ready_cons[k];
    end
  end

  assign link.ready_out   = ~full[link.selector];
  assign link.valid_out_0 = ~empty[0];
  assign link.valid_out_1 = ~empty[1];
  assign link.data_out_0  = head[0];
  assign link.data_out_1  = head[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        case ({push[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + OCC_W'(1);
          2'b01:   occ[k] <= occ[k] - OCC_W'(1);
          default: occ[k] <= occ[k];
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= link.data_in;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_0 <= '0;
      count_1 <= '0;
    end else begin
      if (push[0] && (count_0 != '1)) count_0 <= count_0 + 8'd1;
      if (push[1] && (count_1 != '1)) count_1 <= count_1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_12.sv
// Directed self-checking bench for demux_12; counter checks are built only
// when DEMUX_STATS_EN is defined.
module tb_demux_12;
  logic clk;
  logic reset;

  demux_12_if #(.DATA_WIDTH(8)) bus ();

`ifdef DEMUX_STATS_EN
  logic [7:0] count_0;
  logic [7:0] count_1;
`endif

  demux_12 #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .link   (bus.slave)
`ifdef DEMUX_STATS_EN
    ,
    .count_0(count_0),
    .count_1(count_1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] drain_exp [4];
  logic [7:0] q [$];
  logic [7:0] word;
  int         occ;
  int         sent;
  int         got;
  bit         do_pop;
  bit         do_acc;

  initial begin
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05};
    bus.data_in    = '0;
    bus.valid_in   = 1'b0;
    bus.selector   = 1'b0;
    bus.ready_in_0 = 1'b0;
    bus.ready_in_1 = 1'b0;
    reset          = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_v0", bus.valid_out_0, 0);
    check("rst_v1", bus.valid_out_1, 0);
    check("rst_d0", bus.data_out_0, 0);
    check("rst_d1", bus.data_out_1, 0);
    check("rst_rdy", bus.ready_out, 1);
    reset = 1'b1;
    tick();

    // Routing
    bus.ready_in_0 = 1'b1;
    bus.ready_in_1 = 1'b1;
    bus.valid_in   = 1'b1;
    bus.selector   = 1'b0;
    bus.data_in    = 8'hA5;
    tick();
    check("route_v0", bus.valid_out_0, 1);
    check("route_d0", bus.data_out_0, 8'hA5);
    check("route_v1_idle", bus.valid_out_1, 0);
    bus.selector = 1'b1;
    bus.data_in  = 8'h3C;
    tick();
    check("route_v0_drop", bus.valid_out_0, 0);
    check("route_v1", bus.valid_out_1, 1);
    check("route_d1", bus.data_out_1, 8'h3C);
    bus.valid_in = 1'b0;
    tick();
    check("route_v1_drop", bus.valid_out_1, 0);

    // Fill channel 0, then show channel 1 is not blocked
    bus.ready_in_0 = 1'b0;
    bus.ready_in_1 = 1'b0;
    bus.valid_in   = 1'b1;
    bus.selector   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.data_in = 8'(i);
      tick();
    end
    bus.data_in = 8'h05;
    #1;
    check("fill_rdy0", bus.ready_out, 0);
    check("fill_head", bus.data_out_0, 8'h01);
    bus.selector = 1'b1;
    bus.data_in  = 8'h10;
    #1;
    check("fill_rdy1", bus.ready_out, 1);
    tick();
    check("fill_v1", bus.valid_out_1, 1);
    check("fill_d1", bus.data_out_1, 8'h10);

    // Full channel with simultaneous pop: push refused, then accepted
    bus.selector   = 1'b0;
    bus.data_in    = 8'h05;
    bus.ready_in_0 = 1'b1;
    #1;
    check("full_rdy", bus.ready_out, 0);
    tick();
    check("full_pop_head", bus.data_out_0, 8'h02);
    check("full_rdy_after", bus.ready_out, 1);
    bus.ready_in_0 = 1'b0;
    tick();
    check("full_again", bus.ready_out, 0);
    check("full_head_kept", bus.data_out_0, 8'h02);
    bus.valid_in   = 1'b0;
    bus.ready_in_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_v0", bus.valid_out_0, 1);
      check("drain_d0", bus.data_out_0, drain_exp[i]);
      tick();
    end
    check("drain_empty_v0", bus.valid_out_0, 0);
    check("drain_empty_d0", bus.data_out_0, 0);
    bus.ready_in_1 = 1'b1;
    check("drain_d1", bus.data_out_1, 8'h10);
    tick();
    check("drain_empty_v1", bus.valid_out_1, 0);

    // Asynchronous reset with words queued
    bus.ready_in_0 = 1'b0;
    bus.ready_in_1 = 1'b0;
    bus.valid_in   = 1'b1;
    bus.selector   = 1'b0;
    bus.data_in    = 8'h77;
    tick();
    bus.selector = 1'b1;
    bus.data_in  = 8'h88;
    tick();
    bus.valid_in = 1'b0;
    check("pre_arst_v0", bus.valid_out_0, 1);
    check("pre_arst_v1", bus.valid_out_1, 1);
    reset = 1'b0;
    #1;
    check("arst_v0", bus.valid_out_0, 0);
    check("arst_v1", bus.valid_out_1, 0);
    check("arst_d0", bus.data_out_0, 0);
    check("arst_d1", bus.data_out_1, 0);
    tick();
    reset = 1'b1;
    tick();

    // Wrap: 10 words through channel 1 with a toggling consumer
    occ  = 0;
    sent = 0;
    got  = 0;
    bus.selector   = 1'b1;
    bus.ready_in_0 = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      word           = 8'hC0 + 8'(sent);
      bus.ready_in_1 = (cyc % 2 == 0);
      bus.valid_in   = (sent < 10);
      bus.data_in    = word;
      #1;
      check("wrap_rdy", bus.ready_out, 32'(occ < 4));
      check("wrap_vld", bus.valid_out_1, 32'(occ > 0));
      do_pop = (occ > 0) && bus.ready_in_1;
      do_acc = bus.valid_in && (occ < 4);
      if (do_pop) check("wrap_data", bus.data_out_1, q[0]);
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        got++;
        occ--;
      end
      if (do_acc) begin
        q.push_back(word);
        sent++;
        occ++;
      end
    end
    bus.valid_in   = 1'b0;
    bus.ready_in_1 = 1'b0;
    check("wrap_count", got, 10);
    check("wrap_empty", bus.valid_out_1, 0);

`ifdef DEMUX_STATS_EN
    // Saturating counters
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("stats_rst0", count_0, 0);
    bus.selector   = 1'b0;
    bus.ready_in_0 = 1'b1;
    bus.valid_in   = 1'b1;
    bus.data_in    = 8'h5A;
    repeat (255) tick();
    check("stats_c0_255", count_0, 255);
    repeat (45) tick();
    bus.selector   = 1'b1;
    bus.ready_in_1 = 1'b1;
    repeat (3) tick();
    bus.valid_in = 1'b0;
    tick();
    check("stats_c0_sat", count_0, 255);
    check("stats_c1", count_1, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
